// File: rtl/tt_sweep_pkg.sv
// Shared types and CRC-32 constants for the truth-table sweep controller.
package tt_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        EMIT,
        DONE
    } state_t;

    localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

endpackage

// File: rtl/tt_crc32_acc.sv
// One-cycle WORD_W-bit CRC-32 update, MSB first, with clear and enable.
module tt_crc32_acc
    import tt_sweep_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [WORD_W-1:0] data,
    output logic [31:0]       crc,
    output logic [31:0]       crc_next
);

    always_comb begin
        crc_next = crc;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (crc_next[31] ^ data[i])
                crc_next = {crc_next[30:0], 1'b0} ^ CRC32_POLY;
            else
                crc_next = {crc_next[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= CRC32_INIT;
        else if (clr)
            crc <= CRC32_INIT;
        else if (en)
            crc <= crc_next;
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive input sweep and truth-table streamer for a small combinational block.
// Optional CRC-32 signature of the stream when TT_SWEEP_CRC_EN is defined.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 7,
    parameter int N_OUT  = 2,
    parameter int WORD_W = 32,
    parameter int SETTLE = 1,
    localparam int LW = $clog2(WORD_W),
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   dut_x,
    input  logic [N_OUT-1:0]  dut_f,
    output logic              busy,
    output logic              done,
    output logic              tt_valid,
    input  logic              tt_ready,
    output logic [WORD_W-1:0] tt_word,
    output logic [OW-1:0]     tt_out_idx,
    output logic [N_IN-LW-1:0] tt_word_idx,
    output logic [31:0]       sig
);

    localparam logic [N_IN-1:0] VONE = 1;
    localparam logic [SW-1:0]   CONE = 1;
    localparam logic [SW-1:0]   CLAST = SW'(SETTLE - 1);
    localparam logic [OW-1:0]   OONE = 1;
    localparam logic [OW-1:0]   OLAST = OW'(N_OUT - 1);

    state_t            state;
    state_t            nxt;
    logic [N_IN-1:0]   vec;
    logic [SW-1:0]     cnt;
    logic [OW-1:0]     out_idx;
    logic [WORD_W-1:0] packer [N_OUT];
    logic              done_q;

    logic hs;
    logic last_out;
    logic last_vec;
    logic blk_end;
    logic settled;
    logic kill;

    assign hs       = (state == EMIT) && tt_ready;
    assign last_out = (out_idx == OLAST);
    assign last_vec = (vec == '1);
    assign blk_end  = (vec[LW-1:0] == '1);
    assign settled  = (cnt == CLAST);
    assign kill     = abort && (state != IDLE);

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = DRIVE;
            DRIVE:   if (settled) nxt = SAMPLE;
            SAMPLE:  nxt = blk_end ? EMIT : DRIVE;
            EMIT:    if (hs && last_out) nxt = last_vec ? DONE : DRIVE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (kill)
            nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            vec     <= '0;
            cnt     <= '0;
            out_idx <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < N_OUT; k++)
                packer[k] <= '0;
        end else begin
            state  <= nxt;
            // done is the registered image of the DONE state
            done_q <= (state == DONE) && !abort;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        vec     <= '0;
                        cnt     <= '0;
                        out_idx <= '0;
                    end
                end
                DRIVE: cnt <= settled ? '0 : cnt + CONE;
                SAMPLE: begin
                    for (int k = 0; k < N_OUT; k++)
                        packer[k][vec[LW-1:0]] <= dut_f[k];
                    if (blk_end)
                        out_idx <= '0;
                    else
                        vec <= vec + VONE;
                end
                EMIT: begin
                    if (hs) begin
                        out_idx <= last_out ? '0 : out_idx + OONE;
                        if (last_out && !last_vec)
                            vec <= vec + VONE;
                    end
                end
                default: ;
            endcase
            if (kill) begin
                cnt     <= '0;
                out_idx <= '0;
                for (int k = 0; k < N_OUT; k++)
                    packer[k] <= '0;
            end
        end
    end

    assign dut_x       = vec;
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign tt_valid    = (state == EMIT);
    assign tt_word     = packer[out_idx];
    assign tt_out_idx  = out_idx;
    assign tt_word_idx = vec[N_IN-1:LW];

`ifdef TT_SWEEP_CRC_EN
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [31:0] sig_q;

    tt_crc32_acc #(.WORD_W(WORD_W)) u_crc (
        .clk      (clk),
        .rst      (rst),
        .clr      (start && (state == IDLE)),
        .en       (hs && !abort),
        .data     (tt_word),
        .crc      (crc),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sig_q <= '0;
        else if (start && (state == IDLE))
            sig_q <= '0;
        else if (hs && last_out && last_vec && !abort)
            sig_q <= crc_next ^ CRC32_XOROUT;
    end

    assign sig = sig_q;
`else
    assign sig = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed self-checking bench for tt_sweep_ctrl (default parameters).
module tb_tt_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [6:0]  dut_x;
    logic [1:0]  dut_f;
    logic        busy;
    logic        done;
    logic        tt_valid;
    logic        tt_ready;
    logic [31:0] tt_word;
    logic [0:0]  tt_out_idx;
    logic [1:0]  tt_word_idx;
    logic [31:0] sig;

    int checks = 0;
    int failures = 0;
    int mode = 0;

    logic [31:0] got_w  [16];
    logic [31:0] got_oi [16];
    logic [31:0] got_wi [16];
    int nw;
    int dones;
    int dc;

    tt_sweep_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .dut_x       (dut_x),
        .dut_f       (dut_f),
        .busy        (busy),
        .done        (done),
        .tt_valid    (tt_valid),
        .tt_ready    (tt_ready),
        .tt_word     (tt_word),
        .tt_out_idx  (tt_out_idx),
        .tt_word_idx (tt_word_idx),
        .sig         (sig)
    );

    always #5 clk = ~clk;

    function automatic logic fmod(int m, int k, logic [6:0] x);
        if (m == 0)
            return (k == 0) ? x[0] : &x;
        return (k == 0) ? ((x[0] & x[1]) | x[5]) : (x[6] ^ x[2]);
    endfunction

    always_comb dut_f = {fmod(mode, 1, dut_x), fmod(mode, 0, dut_x)};

    function automatic logic [31:0] exp_word(int m, int k, int w);
        logic [31:0] r;
        logic [6:0]  x;
        r = '0;
        for (int j = 0; j < 32; j++) begin
            x = 7'(w * 32 + j);
            r[j] = fmod(m, k, x);
        end
        return r;
    endfunction

    // byte-wise, MSB-first CRC-32/BZIP2 core (no final XOR here)
    function automatic logic [31:0] crc_upd(logic [31:0] c, logic [31:0] w);
        logic [31:0] r;
        logic [7:0]  b;
        r = c;
        for (int i = 3; i >= 0; i--) begin
            b = w[i*8 +: 8];
            r = r ^ {b, 24'h0};
            for (int j = 0; j < 8; j++)
                r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input int stall, input bit pulses, input int abort_at,
                         output int done_cyc);
        int stall_left;
        bit captured;
        logic [31:0] w0;
        logic [31:0] oi0;
        logic [31:0] wi0;
        nw = 0;
        dones = 0;
        done_cyc = -1;
        stall_left = stall;
        captured = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 700; n++) begin
            start = pulses && (n == 5 || n == 50);
            abort = (n == abort_at);
            if (tt_valid && stall_left > 0) begin
                tt_ready = 1'b0;
                if (!captured) begin
                    w0 = tt_word;
                    oi0 = 32'(tt_out_idx);
                    wi0 = 32'(tt_word_idx);
                    captured = 1;
                end else begin
                    chk("stall_word", tt_word, w0);
                    chk("stall_oidx", 32'(tt_out_idx), oi0);
                    chk("stall_widx", 32'(tt_word_idx), wi0);
                end
                stall_left--;
            end else begin
                tt_ready = 1'b1;
            end
            if (tt_valid && tt_ready && nw < 16) begin
                got_w[nw] = tt_word;
                got_oi[nw] = 32'(tt_out_idx);
                got_wi[nw] = 32'(tt_word_idx);
                nw++;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                done_cyc = n;
            end
            if (done || n == abort_at)
                break;
        end
        start = 1'b0;
        abort = 1'b0;
        tt_ready = 1'b1;
        if (abort_at == 0)
            chk("sweep_timeout", 32'(done_cyc > 0), 32'd1);
    endtask

    task automatic check_words(input int m);
        chk("word_count", 32'(nw), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("oidx_%0d", i), got_oi[i], 32'(i % 2));
            chk($sformatf("widx_%0d", i), got_wi[i], 32'(i / 2));
            chk($sformatf("word_%0d", i), got_w[i], exp_word(m, i % 2, i / 2));
        end
    endtask

    initial begin
        logic [31:0] c;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tt_ready = 1'b1;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(tt_valid), 32'd0);
        chk("rst_x", 32'(dut_x), 32'd0);
        chk("rst_word", tt_word, 32'd0);
        chk("rst_sig", sig, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // constant hand-derived tables for mode 0
        chk("hand_o0", exp_word(0, 0, 2), 32'hAAAAAAAA);
        chk("hand_o1w3", exp_word(0, 1, 3), 32'h80000000);

        sweep(0, 0, 0, dc);
        chk("done_cycle", 32'(dc), 32'd265);
        check_words(0);
        chk("x_after", 32'(dut_x), 32'h7F);
`ifndef TT_SWEEP_CRC_EN
        chk("sig_zero", sig, 32'd0);
`endif
        @(posedge clk);
        #1;
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        sweep(10, 0, 0, dc);
        chk("stall_done_cycle", 32'(dc), 32'd275);
        check_words(0);

        sweep(0, 0, 100, dc);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(tt_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        dones = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (done || busy)
                dones++;
        end
        chk("abort_quiet", 32'(dones), 32'd0);
        sweep(0, 0, 0, dc);
        chk("post_abort_cycle", 32'(dc), 32'd265);
        check_words(0);

        sweep(0, 1, 0, dc);
        chk("pulse_cycle", 32'(dc), 32'd265);
        chk("pulse_dones", 32'(dones), 32'd1);
        check_words(0);
        @(posedge clk);
        #1;
        chk("pulse_idle", 32'(busy), 32'd0);

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_x", 32'(dut_x), 32'd10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_x", 32'(dut_x), 32'd0);
        chk("arst_valid", 32'(tt_valid), 32'd0);
        chk("arst_word", tt_word, 32'd0);
        chk("arst_sig", sig, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("no_resume_busy", 32'(busy), 32'd0);
        chk("no_resume_x", 32'(dut_x), 32'd0);

`ifdef TT_SWEEP_CRC_EN
        mode = 1;
        sweep(0, 0, 0, dc);
        check_words(1);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++)
            c = crc_upd(c, exp_word(1, i % 2, i / 2));
        chk("crc_sig", sig, c ^ 32'hFFFFFFFF);
`else
        c = 32'd0;
        mode = 1;
        sweep(0, 0, 0, dc);
        check_words(1);
        chk("sig_zero_m1", sig, c);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
